// File: rtl/hci_core_req_buffer.sv
// hci_core_req_buffer: request FIFO between a core and the log interconnect,
// with registered in-order responses and outstanding-transaction tracking.
module hci_core_req_buffer #(
  parameter int DEPTH   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BW      = 8,
  parameter int UW      = 1,
  parameter int MAX_OUT = DEPTH + 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           core_req_i,
  output logic                           core_gnt_o,
  input  logic [AW-1:0]                  core_add_i,
  input  logic                           core_wen_i,
  input  logic [DW-1:0]                  core_data_i,
  input  logic [DW/BW-1:0]               core_be_i,
  input  logic [UW-1:0]                  core_user_i,
  output logic                           core_r_valid_o,
  output logic [DW-1:0]                  core_r_data_o,
  output logic [UW-1:0]                  core_r_user_o,
  output logic                           ic_req_o,
  input  logic                           ic_gnt_i,
  output logic [AW-1:0]                  ic_add_o,
  output logic                           ic_wen_o,
  output logic [DW-1:0]                  ic_data_o,
  output logic [DW/BW-1:0]               ic_be_o,
  output logic [UW-1:0]                  ic_user_o,
  input  logic                           ic_r_valid_i,
  input  logic [DW-1:0]                  ic_r_data_i,
  input  logic [UW-1:0]                  ic_r_user_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic [$clog2(MAX_OUT+1)-1:0]   outstanding_o,
  output logic                           err_o
);
  localparam int BEW = DW / BW;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int EW  = AW + 1 + DW + BEW + UW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d, drop;
  logic          r_valid_q, err_q, err_d;
  logic [DW-1:0] r_data_q;
  logic [UW-1:0] r_user_q;
  logic          full, empty, push, pop, unexp, fwd;

  // A response is unexpected when every accepted, undelivered transaction is
  // still sitting in the FIFO (the one in the response register is excluded).
  always_comb begin
    full       = count_q == CW'(DEPTH);
    empty      = count_q == '0;
    core_gnt_o = !full && outst_q < OW'(MAX_OUT) && !clear_i;
    push       = core_req_i && core_gnt_o;
    pop        = !empty && ic_gnt_i;
    unexp      = ic_r_valid_i && (outst_q - OW'(r_valid_q) == OW'(count_q));
    fwd        = ic_r_valid_i && !unexp;
    drop       = clear_i ? OW'(count_q) - OW'(pop) : '0;
    count_d    = clear_i ? '0 : count_q + CW'(push) - CW'(pop);
    outst_d    = outst_q + OW'(push) - OW'(r_valid_q) - drop;
    wptr_d     = clear_i ? '0 : !push ? wptr_q : wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + PW'(1);
    rptr_d     = clear_i ? '0 : !pop ? rptr_q : rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + PW'(1);
    err_d      = err_q || unexp;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_user_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      r_valid_q <= fwd;
      err_q     <= err_d;
      if (fwd) begin
        r_data_q <= ic_r_data_i;
        r_user_q <= ic_r_user_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {core_add_i, core_wen_i, core_data_i, core_be_i, core_user_i};
  end

  assign {ic_add_o, ic_wen_o, ic_data_o, ic_be_o, ic_user_o} = mem_q[rptr_q];
  assign ic_req_o       = !empty;
  assign count_o        = count_q;
  assign outstanding_o  = outst_q;
  assign core_r_valid_o = r_valid_q;
  assign core_r_data_o  = r_data_q;
  assign core_r_user_o  = r_user_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_hci_core_req_buffer.sv
// tb_hci_core_req_buffer: directed vector table, reset/clear sequences and a
// randomized run against a queue-based transaction model.
module tb_hci_core_req_buffer;
  logic        clk, rst_i, clear_i;
  logic        core_req_i, core_gnt_o, core_wen_i, core_r_valid_o;
  logic [31:0] core_add_i, core_data_i, core_r_data_o;
  logic [3:0]  core_be_i;
  logic [0:0]  core_user_i, core_r_user_o;
  logic        ic_req_o, ic_gnt_i, ic_wen_o, ic_r_valid_i;
  logic [31:0] ic_add_o, ic_data_o, ic_r_data_i;
  logic [3:0]  ic_be_o;
  logic [0:0]  ic_user_o, ic_r_user_i;
  logic [2:0]  count_o, outstanding_o;
  logic        err_o;

  hci_core_req_buffer dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_add_i(core_add_i),
    .core_wen_i(core_wen_i), .core_data_i(core_data_i), .core_be_i(core_be_i),
    .core_user_i(core_user_i), .core_r_valid_o(core_r_valid_o),
    .core_r_data_o(core_r_data_o), .core_r_user_o(core_r_user_o),
    .ic_req_o(ic_req_o), .ic_gnt_i(ic_gnt_i), .ic_add_o(ic_add_o), .ic_wen_o(ic_wen_o),
    .ic_data_o(ic_data_o), .ic_be_o(ic_be_o), .ic_user_o(ic_user_o),
    .ic_r_valid_i(ic_r_valid_i), .ic_r_data_i(ic_r_data_i), .ic_r_user_i(ic_r_user_i),
    .count_o(count_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic req, wen, gnt, rv, clr;
    logic [31:0] add, rdata;
    int cnt, out;
    logic cg, icr, vld, err;
    logic [31:0] erd;
  } vec_t;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
    logic [3:0]  be;
    logic        user;
  } req_t;

  int n_cmp = 0, n_fail = 0;
  vec_t tbl[21];
  req_t q[$];
  req_t h;
  int accepted, delivered, n_push_fr;
  logic resp_pend, rv_now, exp_v, e_gnt, e_icr, resp_u, exp_u;
  logic [31:0] resp_d, exp_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic req, wen, input logic [31:0] add, input logic gnt, rv,
                              input logic [31:0] rdata, input logic clr, input int cnt, out,
                              input logic cg, icr, vld, err, input logic [31:0] erd);
    vec_t v;
    v.req = req; v.wen = wen; v.add = add; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.clr = clr;
    v.cnt = cnt; v.out = out; v.cg = cg; v.icr = icr; v.vld = vld; v.err = err; v.erd = erd;
    return v;
  endfunction

  task automatic idle();
    core_req_i = 0; core_wen_i = 0; core_add_i = 0; core_data_i = 0; core_be_i = 0;
    core_user_i = 0; ic_gnt_i = 0; ic_r_valid_i = 0; ic_r_data_i = 0; ic_r_user_i = 0; clear_i = 0;
  endtask

  initial begin
    // single read, fill/one pop, clear with one in flight, unexpected response
    tbl[0]  = mk(1, 1, 32'h100, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,       1, 0, 0,            0, 1, 1, 1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,       0, 1, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,       0, 0, 0,            0, 0, 1, 1, 0, 1, 0, 32'hDEADBEEF);
    tbl[4]  = mk(0, 0, 0,       0, 0, 0,            0, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 32'h200, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 32'h204, 0, 0, 0,            0, 1, 1, 1, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 32'h208, 0, 0, 0,            0, 2, 2, 1, 1, 0, 0, 0);
    tbl[8]  = mk(1, 0, 32'h20C, 0, 0, 0,            0, 3, 3, 1, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 32'h210, 0, 0, 0,            0, 4, 4, 0, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 32'h210, 1, 0, 0,            0, 4, 4, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 0,       0, 1, 32'h5555,     0, 3, 4, 1, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,       0, 0, 0,            0, 3, 4, 1, 1, 1, 0, 32'h5555);
    tbl[13] = mk(0, 0, 0,       0, 0, 0,            0, 3, 3, 1, 1, 0, 0, 0);
    tbl[14] = mk(1, 0, 32'h50,  1, 0, 0,            0, 3, 3, 1, 1, 0, 0, 0);
    tbl[15] = mk(0, 0, 0,       0, 1, 32'h1234,     1, 3, 4, 0, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 0,       0, 0, 0,            0, 0, 1, 1, 0, 1, 0, 32'h1234);
    tbl[17] = mk(0, 0, 0,       0, 0, 0,            0, 0, 0, 1, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0,       0, 1, 32'hBAD,      0, 0, 0, 1, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0,       0, 0, 0,            0, 0, 0, 1, 0, 0, 1, 0);
    tbl[20] = mk(0, 0, 0,       0, 0, 0,            0, 0, 0, 1, 0, 0, 1, 0);

    idle();
    rst_i = 1;
    #1;
    chk("reset count", count_o, 0);
    chk("reset outstanding", outstanding_o, 0);
    chk("reset ic_req", ic_req_o, 0);
    chk("reset r_valid", core_r_valid_o, 0);
    chk("reset err", err_o, 0);
    @(negedge clk); @(negedge clk);
    rst_i = 0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      core_req_i = tbl[i].req; core_wen_i = tbl[i].wen; core_add_i = tbl[i].add;
      ic_gnt_i = tbl[i].gnt; ic_r_valid_i = tbl[i].rv; ic_r_data_i = tbl[i].rdata; clear_i = tbl[i].clr;
      #1;
      chk($sformatf("row%0d count", i), count_o, tbl[i].cnt);
      chk($sformatf("row%0d outstanding", i), outstanding_o, tbl[i].out);
      chk($sformatf("row%0d core_gnt", i), core_gnt_o, tbl[i].cg);
      chk($sformatf("row%0d ic_req", i), ic_req_o, tbl[i].icr);
      chk($sformatf("row%0d r_valid", i), core_r_valid_o, tbl[i].vld);
      chk($sformatf("row%0d err", i), err_o, tbl[i].err);
      if (tbl[i].vld) chk($sformatf("row%0d r_data", i), core_r_data_o, tbl[i].erd);
      if (i == 1) chk("row1 ic_add", ic_add_o, 32'h100);
    end

    // reset in the middle of traffic, with a response arriving
    @(negedge clk); idle(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h300;
    @(negedge clk); core_add_i = 32'h304;
    @(negedge clk); core_add_i = 32'h308; ic_gnt_i = 1;
    @(negedge clk); core_req_i = 0; ic_gnt_i = 0; ic_r_valid_i = 1; ic_r_data_i = 32'hCAFE; ic_r_user_i = 1;
    #1;
    chk("pre-reset count", count_o, 2);
    chk("pre-reset outstanding", outstanding_o, 3);
    rst_i = 1;
    #1;
    chk("midrst count", count_o, 0);
    chk("midrst outstanding", outstanding_o, 0);
    chk("midrst ic_req", ic_req_o, 0);
    chk("midrst r_valid", core_r_valid_o, 0);
    chk("midrst r_data", core_r_data_o, 0);
    chk("midrst r_user", core_r_user_o, 0);
    chk("midrst err", err_o, 0);
    @(negedge clk);
    rst_i = 0; ic_r_valid_i = 0; core_req_i = 1; core_add_i = 32'h400;
    #1;
    chk("post-reset core_gnt", core_gnt_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); core_req_i = 0;
      #1;
      chk($sformatf("post-reset r_valid %0d", i), core_r_valid_o, 0);
    end
    chk("post-reset count", count_o, 1);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;

    // randomized traffic against the transaction model
    accepted = 0; delivered = 0; n_push_fr = 0;
    resp_pend = 0; resp_d = 0; resp_u = 0; exp_v = 0; exp_d = 0; exp_u = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      core_req_i  = c < 200 ? 1'b1 : ($urandom_range(0, 2) != 0);
      core_wen_i  = 1'($urandom_range(0, 1));
      core_add_i  = $urandom;
      core_data_i = $urandom;
      core_be_i   = 4'($urandom_range(0, 15));
      core_user_i = 1'($urandom_range(0, 1));
      ic_gnt_i    = c < 200 ? 1'b1 : c < 1500 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rv_now      = resp_pend;
      ic_r_valid_i = rv_now; ic_r_data_i = resp_d; ic_r_user_i = resp_u;
      #1;
      e_gnt = q.size() < 4 && (accepted - delivered) < 6;
      e_icr = q.size() > 0;
      chk("rnd count", count_o, q.size());
      chk("rnd outstanding", outstanding_o, accepted - delivered);
      chk("rnd core_gnt", core_gnt_o, e_gnt);
      chk("rnd ic_req", ic_req_o, e_icr);
      if (e_icr) chk("rnd ic_fields", {ic_add_o, ic_wen_o, ic_data_o, ic_be_o, ic_user_o}, q[0]);
      chk("rnd r_valid", core_r_valid_o, exp_v);
      if (exp_v) chk("rnd r_data", {core_r_user_o, core_r_data_o}, {exp_u, exp_d});
      chk("rnd err", err_o, 0);
      delivered += int'(exp_v);
      exp_v = rv_now; exp_d = resp_d; exp_u = resp_u;
      resp_pend = 0;
      if (e_icr && ic_gnt_i) begin
        h = q.pop_front();
        resp_pend = 1;
        resp_d = h.wen ? h.add ^ 32'hA5A5_5A5A : $urandom;
        resp_u = 1'($urandom_range(0, 1));
      end
      if (core_req_i && e_gnt) begin
        q.push_back({core_add_i, core_wen_i, core_data_i, core_be_i, core_user_i[0]});
        accepted++;
        if (c < 200) n_push_fr++;
      end
    end
    chk("full-rate throughput", n_push_fr, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hci_core_req_buffer.md
HCI_CORE_REQ_BUFFER -- requirements
Module: hci_core_req_buffer

Interface
REQ-001 SHALL have parameters: DEPTH, 4, request FIFO entries (>=2); AW, 32, address width; DW, 32, data width; BW, 8, bits per byte-enable; UW, 1, user width (>=1); MAX_OUT, DEPTH+2, outstanding-transaction limit.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with ports as follows (clock and reset first):
  clk_i  in  1  clock
  rst_i  in  1  asynchronous active-high reset
  clear_i  in  1  synchronous clear
  core_req_i  in  1  core request
  core_gnt_o  out  1  core grant
  core_add_i  in  AW  address
  core_wen_i  in  1  1=read, 0=write
  core_data_i  in  DW  write data
  core_be_i  in  DW/BW  byte enables
  core_user_i  in  UW  write user
  core_r_valid_o  out  1  response valid
  core_r_data_o  out  DW  read data
  core_r_user_o  out  UW  read user
  ic_req_o  out  1  request to log interconnect
  ic_gnt_i  in  1  interconnect grant
  ic_add_o, ic_wen_o, ic_data_o, ic_be_o, ic_user_o  out  as core side  buffered request fields
  ic_r_valid_i  in  1  response valid (1 cycle after grant, reads and writes)
  ic_r_data_i  in  DW  read data
  ic_r_user_i  in  UW  read user
  count_o  out  $clog2(DEPTH+1)  FIFO occupancy
  outstanding_o  out  $clog2(MAX_OUT+1)  accepted, unresponded transactions
  err_o  out  1  sticky unexpected-response flag

Function
REQ-003 SHALL buffer requests in a DEPTH-entry FIFO holding {add, wen, data, be, user}.
REQ-004 SHALL drive core_gnt_o = !full && (outstanding < MAX_OUT) && !clear_i, combinationally.
REQ-005 SHALL push when core_req_i && core_gnt_o.
REQ-006 SHALL drive ic_req_o = !empty, with ic_* fields from the head entry, stable while ic_req_o && !ic_gnt_i.
REQ-007 SHALL pop when ic_req_o && ic_gnt_i.
REQ-008 SHALL have no fall-through: a push into an empty FIFO at cycle t makes ic_req_o high at t+1.
REQ-009 SHALL update count as +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-010 SHALL prevent push when full, because core_gnt_o=0 when full.
REQ-011 SHALL register responses: core_r_valid_o, core_r_data_o and core_r_user_o at t+1 equal the ic_r_* inputs at t; data registers load only when ic_r_valid_i=1.
REQ-012 SHALL give minimum read latency core_req_i to core_r_valid_o of 3 cycles with an immediate interconnect grant.
REQ-013 SHALL update outstanding as +1 on push and -1 when core_r_valid_o=1, unchanged when both occur, and never exceeding MAX_OUT.
REQ-014 SHALL, when ic_r_valid_i=1 while outstanding equals count (no transaction issued), set err_o, keep it set until reset, and not forward that response.
REQ-015 SHALL, on clear_i=1, empty the FIFO, zero count, and drop the head request on the next cycle; the outstanding counter keeps tracking issued transactions (decremented to zero by their responses), and err_o is unaffected.
REQ-016 SHALL preserve ordering: responses return in issue order, and no reordering or response storage beyond one register is permitted.

Reset
REQ-017 SHALL, while rst_i=1, asynchronously force: FIFO empty, count_o=0, outstanding_o=0, ic_req_o=0, core_r_valid_o=0, core_r_data_o=0, core_r_user_o=0, err_o=0, read/write pointers=0.
REQ-018 SHALL, on reset mid-operation, discard all buffered and in-flight transactions, with no response emitted after deassertion.
REQ-019 SHALL show core_gnt_o=1 in the first cycle after reset deassertion when core_req_i=1.

Verification
REQ-020 SHALL cover a single read: push add=0x100 at t, ic_gnt_i=1 at t+1, ic_r_data_i=0xDEADBEEF at t+2 -> core_r_valid_o=1 with 0xDEADBEEF at t+3, and outstanding_o values 1,1,1,0 over t+1..t+4.
REQ-021 SHALL cover fill with DEPTH=4 and ic_gnt_i=0: 4 pushes -> count_o=4, core_gnt_o=0; one ic_gnt_i pulse -> count_o=3, core_gnt_o=1 the same cycle as count_o=3.
REQ-022 SHALL cover back-to-back traffic: continuous push with ic_gnt_i=1 -> count_o steady at 1, throughput 1 per cycle, responses in order of add.
REQ-023 SHALL cover an unexpected response: ic_r_valid_i=1 with empty buffer and outstanding=0 -> err_o=1 next cycle and core_r_valid_o stays 0.
REQ-024 SHALL cover clear: count_o=3, one issued transaction in flight, clear_i pulsed -> count_o=0, ic_req_o=0 next cycle, and the in-flight response is still delivered with outstanding_o reaching 0.
REQ-025 SHALL cover reset mid-operation: rst_i asserted with count_o=2 and ic_r_valid_i=1 -> all outputs per REQ-017 immediately, and no core_r_valid_o after release.
